sseg_capture: RTL and testbench
===============================

# sseg_capture

Receive-side monitor for the four-digit multiplexed seven-segment bus. Samples the active-low anode and cathode lines produced by the display multiplexer, waits for each digit to settle, inverts the segment encoding back to BCD, and presents a complete 16-bit frame with a one-cycle valid strobe. Used as an on-chip loopback checker and as the bench-side observer for display logic.

## Interface
- `STABLE_CYCLES`, 8: consecutive identical registered samples of the (an, cath) pair required before a digit is accepted; legal range 2..15.
- `CNT_W`, 4: stability counter width; must hold `STABLE_CYCLES`.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `an` in 4: anodes, active-low. Exactly one low bit selects a digit: `an[3]`=bits 15:12 … `an[0]`=bits 3:0.
- `cath` in 7: segments, active-low, order {a,b,c,d,e,f,g}; 7'b1111111 means blank.
- `bcd_out` out 16: last complete frame.
- `valid` out 1: one-cycle pulse when `bcd_out` updates.
- `digit_err` out 1: at least one digit of the frame just presented was undecodable; updates with `valid`.

## Operation
- `an` and `cath` are registered once (`an_q`, `cath_q`). All logic uses the registered copies.
- A sample is capturable only when `~an_q` is one-hot and `cath_q` is not blank.
- Stability counter: when the registered pair equals the previous registered pair, the counter increments and saturates at `STABLE_CYCLES`. On any change, it clears to 0.
- FSM:
  - IDLE: wait for a capturable pair, then go to SETTLE.
  - SETTLE: if the pair changes, return to IDLE, or stay in SETTLE if the new pair is capturable. If the counter reaches `STABLE_CYCLES-1` while capturable, write the digit and go to HOLD.
  - HOLD: the digit was captured once. Any change of the pair goes to IDLE, or to SETTLE if the new pair is capturable.
- Decode: patterns map to 0–9 as follows.
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4
  - 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9
- Any other non-blank pattern writes 4'hF and sets the frame error accumulator.
- A write stores the nibble in `shadow[pos]` and sets `seen[pos]`. A repeat capture of a position before the frame completes overwrites that nibble.
- Frame completion: when `seen` becomes 4'b1111, the following happen together:
  - `bcd_out` is loaded with shadow, including the digit just written.
  - `digit_err` is loaded with the accumulator.
  - `valid` pulses.
  - `seen` and the accumulator clear.
- Blank samples and zero- or multi-hot anode samples are never captured. They do not clear `seen`.

## Timing
- Reset values:
  - `bcd_out`=16'h0000, `valid`=0, `digit_err`=0.
  - `seen`=0, shadow=16'h0000, accumulator=0.
  - counter=0, FSM=IDLE, `an_q`=4'hF, `cath_q`=7'h7F.
- Latency: if a pair is driven on pins from cycle 0, it is registered at edge 1 and written to shadow at edge `STABLE_CYCLES`. For the fourth digit, `bcd_out`, `digit_err` and `valid` update at edge `STABLE_CYCLES`+1.
- `valid` is high for exactly one cycle per frame. Back-to-back frames need at least 4×`STABLE_CYCLES` cycles.
- A pair held for fewer than `STABLE_CYCLES` registered samples is discarded.
- Reset asserted mid-frame discards partial digits. The first `valid` after reset requires all four positions to be captured afresh.
- If a change of the pair and counter saturation occur in the same cycle, the change wins and nothing is written.

## Configuration
- `SSEG_CAPTURE_HEX_EN` defined: six extra patterns decode as hex letters.
  - 0001000=A, 1100000=b, 0110001=C
  - 1000010=d, 0110000=E, 0111000=F
  - These set no error. A captured 4'hF is then legal, and only unlisted patterns flag `digit_err`.
- Not defined: these six patterns are errors, as in Operation.

## Structure
- Shared package `sseg_pkg` holds:
  - the segment pattern constants for 0–9 and A–F, plus the blank constant;
  - the FSM state encoding (IDLE, SETTLE, HOLD);
  - the anode one-hot position constants.
- The display-side decoder uses the same constants so the two ends cannot diverge.
- One sub-module, `seg_to_bcd`: combinational `cath` → {nibble, err}. It contains the `SSEG_CAPTURE_HEX_EN` conditional.

## Test plan
- Ideal multiplexer model drives 16'h1234 with 16 cycles per digit, `STABLE_CYCLES`=8 → `valid` pulses once per scan, `bcd_out`=16'h1234, `digit_err`=0.
- Digit pair held 5 cycles, interleaved with blanks, for 3 scans → no `valid`, `bcd_out` stays 16'h0000.
- `cath`=7'b1111110 on position `an`=4'b1011 within a 16'h5678 frame → `bcd_out`=16'h5F78, `digit_err`=1. The next clean frame gives `digit_err`=0.
- `an`=4'b1001 (two digits selected) with a valid pattern → ignored, `seen` unchanged.
- `rst` pulsed after two digits of 16'h9012 are captured → no `valid` until a full new scan; then `bcd_out`=16'h9012.
- With `SSEG_CAPTURE_HEX_EN`, drive A,b,C,d → `bcd_out`=16'hABCD, `digit_err`=0. Without it → 16'hFFFF, `digit_err`=1.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared seven-segment encodings, capture FSM states and anode positions.
// Both the display-side decoder and the receive-side capture monitor use these constants.
package sseg_pkg;

  // Active-low segment patterns, bit order {a,b,c,d,e,f,g}
  localparam logic [6:0] Seg0     = 7'b0000001;
  localparam logic [6:0] Seg1     = 7'b1001111;
  localparam logic [6:0] Seg2     = 7'b0010010;
  localparam logic [6:0] Seg3     = 7'b0000110;
  localparam logic [6:0] Seg4     = 7'b1001100;
  localparam logic [6:0] Seg5     = 7'b0100100;
  localparam logic [6:0] Seg6     = 7'b0100000;
  localparam logic [6:0] Seg7     = 7'b0001111;
  localparam logic [6:0] Seg8     = 7'b0000000;
  localparam logic [6:0] Seg9     = 7'b0000100;
  localparam logic [6:0] SegA     = 7'b0001000;
  localparam logic [6:0] SegB     = 7'b1100000;
  localparam logic [6:0] SegC     = 7'b0110001;
  localparam logic [6:0] SegD     = 7'b1000010;
  localparam logic [6:0] SegE     = 7'b0110000;
  localparam logic [6:0] SegF     = 7'b0111000;
  localparam logic [6:0] SegBlank = 7'b1111111;

  // Active-low anode selects; position n drives bcd bits [4n+3:4n]
  localparam logic [3:0] AnPos0 = 4'b1110;
  localparam logic [3:0] AnPos1 = 4'b1101;
  localparam logic [3:0] AnPos2 = 4'b1011;
  localparam logic [3:0] AnPos3 = 4'b0111;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHold
  } cap_state_e;

  function automatic logic capturable(input logic [3:0] an, input logic [6:0] cath);
    logic one_hot;
    one_hot = (an == AnPos0) || (an == AnPos1) || (an == AnPos2) || (an == AnPos3);
    return one_hot && (cath != SegBlank);
  endfunction

endpackage

// File: rtl/seg_to_bcd.sv
// Combinational active-low segment pattern to nibble decoder with error flag.
// Define SSEG_CAPTURE_HEX_EN to accept the A-F letter patterns as legal digits.
module seg_to_bcd
  import sseg_pkg::*;
(
  input  logic [6:0] cath,
  output logic [3:0] nibble,
  output logic       err
);

  always_comb begin
    nibble = 4'hF;
    err    = 1'b0;
    unique case (cath)
      Seg0: nibble = 4'h0;
      Seg1: nibble = 4'h1;
      Seg2: nibble = 4'h2;
      Seg3: nibble = 4'h3;
      Seg4: nibble = 4'h4;
      Seg5: nibble = 4'h5;
      Seg6: nibble = 4'h6;
      Seg7: nibble = 4'h7;
      Seg8: nibble = 4'h8;
      Seg9: nibble = 4'h9;
`ifdef SSEG_CAPTURE_HEX_EN
      SegA: nibble = 4'hA;
      SegB: nibble = 4'hB;
      SegC: nibble = 4'hC;
      SegD: nibble = 4'hD;
      SegE: nibble = 4'hE;
      SegF: nibble = 4'hF;
`endif
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/sseg_capture.sv
// Receive-side monitor for the multiplexed seven-segment bus: settles, decodes and frames digits.
// Optional SSEG_CAPTURE_HEX_EN (in seg_to_bcd) makes the A-F patterns legal.
module sseg_capture
  import sseg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned CNT_W         = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  cath,
  output logic [15:0] bcd_out,
  output logic        valid,
  output logic        digit_err
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CntHit = CNT_W'(STABLE_CYCLES - 1);

  logic [3:0]       an_q;
  logic [6:0]       cath_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cap_state_e       state_q, state_d;
  logic [3:0]       seen_q, seen_d;
  logic [15:0]      shadow_q, shadow_d;
  logic             acc_q, acc_d;
  logic [15:0]      bcd_q;
  logic             valid_q, err_q;

  logic       change, cap_q, cap_in, hit, wr, frame_done;
  logic [3:0] dec_nibble;
  logic       dec_err;

  seg_to_bcd u_dec (
    .cath   (cath_q),
    .nibble (dec_nibble),
    .err    (dec_err)
  );

  // The pair arriving at this edge is compared with the one already registered, so the
  // counter tracks the registered pair without an extra cycle of lag.
  assign change     = (an != an_q) || (cath != cath_q);
  assign cap_q      = capturable(an_q, cath_q);
  assign cap_in     = capturable(an, cath);
  assign frame_done = (seen_q == 4'hF);

  always_comb begin
    if (change) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign hit = !change && cap_q && (cnt_d == CntHit);

  always_comb begin
    state_d = state_q;
    wr      = 1'b0;
    if (change) begin
      state_d = cap_in ? StSettle : StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cap_q) state_d = StSettle;
        end
        StSettle: begin
          if (hit) begin
            wr      = 1'b1;
            state_d = StHold;
          end
        end
        StHold:  state_d = StHold;
        default: state_d = StIdle;
      endcase
    end
  end

  // The frame is published the cycle after its last digit lands in the shadow.
  always_comb begin
    shadow_d = shadow_q;
    seen_d   = seen_q;
    acc_d    = acc_q;
    if (frame_done) begin
      seen_d = '0;
      acc_d  = 1'b0;
    end
    if (wr) begin
      for (int i = 0; i < 4; i++) begin
        if (!an_q[i]) shadow_d[4*i +: 4] = dec_nibble;
      end
      seen_d = seen_d | ~an_q;
      acc_d  = acc_d | dec_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q     <= 4'hF;
      cath_q   <= SegBlank;
      cnt_q    <= '0;
      state_q  <= StIdle;
      seen_q   <= '0;
      shadow_q <= '0;
      acc_q    <= 1'b0;
      bcd_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      an_q     <= an;
      cath_q   <= cath;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      seen_q   <= seen_d;
      shadow_q <= shadow_d;
      acc_q    <= acc_d;
      valid_q  <= frame_done;
      if (frame_done) begin
        bcd_q <= shadow_q;
        err_q <= acc_q;
      end
    end
  end

  assign bcd_out   = bcd_q;
  assign valid     = valid_q;
  assign digit_err = err_q;

endmodule

// File: tb/tb_sseg_capture.sv
// Self-checking bench for sseg_capture: directed scans plus random bus traffic against an
// event-level model (a pair is captured when held >= STABLE_CYCLES, capturable and decoded).
module tb_sseg_capture;

  localparam int unsigned S = 8;
`ifdef SSEG_CAPTURE_HEX_EN
  localparam int NumLegal = 16;
`else
  localparam int NumLegal = 10;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  cath;
  logic [15:0] bcd_out;
  logic        valid;
  logic        digit_err;

  always #5 clk = ~clk;

  sseg_capture #(
    .STABLE_CYCLES (S),
    .CNT_W         (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .an        (an),
    .cath      (cath),
    .bcd_out   (bcd_out),
    .valid     (valid),
    .digit_err (digit_err)
  );

  int errors = 0;
  int checks = 0;

  logic [16:0] obs_q[$];
  logic [16:0] exp_q[$];
  logic [6:0]  ref_pat[16];

  // Model state
  logic [3:0]  m_seen;
  logic [3:0]  m_dig[4];
  logic        m_acc;
  logic [15:0] m_bcd;
  logic        m_err;
  logic [3:0]  cur_an;
  logic [6:0]  cur_cath;
  int          cur_len;

  always @(negedge clk) begin
    if (valid === 1'b1) obs_q.push_back({digit_err, bcd_out});
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] c);
    for (int i = 0; i < NumLegal; i++) begin
      if (c == ref_pat[i]) return {1'b0, 4'(i)};
    end
    return {1'b1, 4'hF};
  endfunction

  function automatic int anode_pos(input logic [3:0] a);
    int p = -1;
    int n = 0;
    for (int i = 0; i < 4; i++) begin
      if (!a[i]) begin
        p = i;
        n++;
      end
    end
    return (n == 1) ? p : -1;
  endfunction

  task automatic model_finalize();
    logic [4:0] d;
    int p;
    p = anode_pos(cur_an);
    if (cur_len >= int'(S) && p >= 0 && cur_cath != 7'h7F) begin
      d        = ref_decode(cur_cath);
      m_dig[p] = d[3:0];
      m_seen[p] = 1'b1;
      m_acc    = m_acc | d[4];
      if (m_seen == 4'hF) begin
        m_bcd = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
        m_err = m_acc;
        exp_q.push_back({m_err, m_bcd});
        m_seen = '0;
        m_acc  = 1'b0;
      end
    end
  endtask

  // Called at a falling edge; the pair is seen by the next n rising edges.
  task automatic apply(input logic [3:0] a, input logic [6:0] c, input int n);
    if (a !== cur_an || c !== cur_cath) begin
      model_finalize();
      cur_an   = a;
      cur_cath = c;
      cur_len  = 0;
    end
    cur_len += n;
    an   = a;
    cath = c;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    // A pair held past its write cycle has already published any frame it completed.
    if (cur_len > int'(S)) model_finalize();
    an   = 4'hF;
    cath = 7'h7F;
    rst  = 1'b1;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    cur_an   = 4'hF;
    cur_cath = 7'h7F;
    cur_len  = 0;
    m_seen   = '0;
    m_acc    = 1'b0;
    m_bcd    = '0;
    m_err    = 1'b0;
    for (int i = 0; i < 4; i++) m_dig[i] = '0;
  endtask

  function automatic logic [3:0] pos_an(input int p);
    logic [3:0] one;
    one = 4'b0001 << p;
    return ~one;
  endfunction

  task automatic scan(input logic [15:0] v, input int n, input int blank);
    logic [3:0] d;
    for (int p = 3; p >= 0; p--) begin
      d = v[4*p +: 4];
      apply(pos_an(p), ref_pat[d], n);
      if (blank > 0) apply(4'hF, 7'h7F, blank);
    end
  endtask

  task automatic check_frames(input string tag);
    logic [16:0] o;
    logic [16:0] e;
    apply(4'hF, 7'h7F, 4);
    chk({tag, " frames"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, " bcd_out@valid"}, o[15:0], e[15:0]);
      chk({tag, " digit_err@valid"}, o[16], e[16]);
    end
    obs_q.delete();
    exp_q.delete();
    chk({tag, " bcd_out idle"}, bcd_out, m_bcd);
    chk({tag, " digit_err idle"}, digit_err, m_err);
    chk({tag, " valid idle"}, valid, 1'b0);
  endtask

  initial begin
    logic [3:0] ra;
    logic [6:0] rc;
    int         sel;

    ref_pat = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
                7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    rst  = 1'b1;
    an   = 4'hF;
    cath = 7'h7F;
    @(negedge clk);
    do_reset();
    chk("reset bcd_out", bcd_out, 16'h0000);
    chk("reset valid", valid, 1'b0);
    chk("reset digit_err", digit_err, 1'b0);

    // Ideal multiplexer, two scans of 1234
    scan(16'h1234, 16, 0);
    scan(16'h1234, 16, 0);
    check_frames("scan1234");

    // Short holds interleaved with blanks never capture
    do_reset();
    for (int k = 0; k < 3; k++) scan(16'h1234, 5, 5);
    check_frames("short5");
    chk("short5 bcd_out zero", bcd_out, 16'h0000);

    // Boundary: exactly S samples captures, S-1 does not
    scan(16'h4321, S, 0);
    check_frames("exactS");
    scan(16'h8765, S - 1, 2);
    check_frames("shortS-1");

    // Undecodable digit at position 2, then a clean frame
    apply(pos_an(3), ref_pat[5], 16);
    apply(pos_an(2), 7'b1111110, 16);
    apply(pos_an(1), ref_pat[7], 16);
    apply(pos_an(0), ref_pat[8], 16);
    check_frames("err5F78");
    scan(16'h5678, 16, 0);
    check_frames("clean5678");

    // Multi-hot, zero-hot and no-anode samples are ignored mid-frame
    apply(pos_an(3), ref_pat[1], 16);
    apply(pos_an(2), ref_pat[2], 16);
    apply(4'b1001, ref_pat[5], 16);
    apply(4'b0000, ref_pat[3], 16);
    apply(4'b1111, ref_pat[8], 16);
    apply(pos_an(1), ref_pat[3], 16);
    apply(pos_an(0), ref_pat[4], 16);
    check_frames("multihot");

    // Reset mid-frame discards captured digits
    apply(pos_an(3), ref_pat[9], 16);
    apply(pos_an(2), ref_pat[0], 16);
    do_reset();
    apply(pos_an(1), ref_pat[1], 16);
    apply(pos_an(0), ref_pat[2], 16);
    check_frames("rst_partial");
    scan(16'h9012, 16, 0);
    check_frames("rst9012");

    // Hex letters A,b,C,d
    do_reset();
    apply(pos_an(3), ref_pat[10], 16);
    apply(pos_an(2), ref_pat[11], 16);
    apply(pos_an(1), ref_pat[12], 16);
    apply(pos_an(0), ref_pat[13], 16);
    check_frames("hexABCD");

    // Random bus traffic
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 40; k++) begin
        sel = int'($urandom_range(0, 9));
        if (sel <= 6) ra = pos_an(int'($urandom_range(0, 3)));
        else if (sel == 7) ra = 4'b1001;
        else if (sel == 8) ra = 4'($urandom);
        else ra = 4'hF;
        sel = int'($urandom_range(0, 9));
        if (sel <= 5) rc = ref_pat[$urandom_range(0, 15)];
        else if (sel <= 7) rc = 7'h7F;
        else rc = 7'($urandom);
        apply(ra, rc, int'($urandom_range(1, 2 * S)));
      end
      check_frames("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
